// File: rtl/prio_encoder8_hs.sv
// Registered priority encoder: captures rising request edges into a pending register
// and retires the selected index one per valid/ready handshake. Define PRIO_ENC_ROUND_ROBIN_EN for rotating priority.
module prio_encoder8_hs #(
  parameter  int N  = 8,
  localparam int CW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          clr,
  input  logic          ready,
  output logic          valid,
  output logic [CW-1:0] code,
  output logic [N-1:0]  pending,
  output logic          overflow
);

  typedef enum logic {IDLE, OFFER} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  req_q, pending_q, pending_d;
  logic [CW-1:0] code_q, code_d;
  logic          valid_q, valid_d, overflow_q, overflow_d;
  logic [N-1:0]  rise, acc_mask, next_vec;
  logic          accept;
  logic [CW-1:0] start;

  // Descending search from start, wrapping; N is a power of two so CW-bit arithmetic wraps mod N.
  function automatic logic [CW-1:0] pick(input logic [N-1:0] v, input logic [CW-1:0] s);
    logic [CW-1:0] idx, res;
    logic          found;
    res   = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = s - CW'(k);
      if (!found && v[idx]) begin
        res   = idx;
        found = 1'b1;
      end
    end
    return res;
  endfunction

`ifdef PRIO_ENC_ROUND_ROBIN_EN
  logic [CW-1:0] last_q, last_d;

  // On accept the just-retired index already counts as "last" for the follow-on pick.
  always_comb begin
    start  = accept ? code_q - CW'(1) : last_q - CW'(1);
    last_d = last_q;
    if (accept) last_d = code_q;
    if (clr)    last_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last_q <= '0;
    else        last_q <= last_d;
`else
  always_comb start = '1;
`endif

  always_comb begin
    rise     = req & ~req_q;
    accept   = (state_q == OFFER) && ready;
    acc_mask = '0;
    if (accept) acc_mask[code_q] = 1'b1;
    next_vec = (pending_q & ~acc_mask) | rise;

    for (int i = 0; i < N; i++) begin
      if (clr)              pending_d[i] = 1'b0;
      else if (rise[i])     pending_d[i] = 1'b1;
      else if (acc_mask[i]) pending_d[i] = 1'b0;
      else                  pending_d[i] = pending_q[i];
    end

    overflow_d = clr ? 1'b0 : (overflow_q | (|(rise & pending_q & ~acc_mask)));

    state_d = state_q;
    valid_d = valid_q;
    code_d  = code_q;
    case (state_q)
      IDLE: if (|pending_q) begin
        code_d  = pick(pending_q, start);
        valid_d = 1'b1;
        state_d = OFFER;
      end
      OFFER: if (ready) begin
        if (|next_vec) begin
          code_d = pick(next_vec, start);
        end else begin
          code_d  = '0;
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        code_d  = '0;
      end
    endcase
    if (clr) begin
      state_d = IDLE;
      valid_d = 1'b0;
      code_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      req_q      <= '0;
      pending_q  <= '0;
      code_q     <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req;
      pending_q  <= pending_d;
      code_q     <= code_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
    end
  end

  assign valid    = valid_q;
  assign code     = code_q;
  assign pending  = pending_q;
  assign overflow = overflow_q;

endmodule
